// File: rtl/issue_hazard_scoreboard_pkg.sv
// rtl/issue_hazard_scoreboard_pkg.sv - shared widths, unit codes and latency lookup for the issue scoreboard
package issue_hazard_scoreboard_pkg;

    localparam int UNIT_ID_SIZE   = 3;
    localparam int REG_ADDR_WIDTH = 7;

    typedef enum logic [UNIT_ID_SIZE-1:0] {
        UNIT_FX1   = 3'd0,
        UNIT_BYTE  = 3'd1,
        UNIT_FX2   = 3'd2,
        UNIT_SPFP  = 3'd3,
        UNIT_SPINT = 3'd4,
        UNIT_PERM  = 3'd5,
        UNIT_LS    = 3'd6
    } unit_e;

    // Unknown codes take the worst-case latency so they can never under-protect a consumer.
    function automatic int unit_lat(
        input logic [UNIT_ID_SIZE-1:0] unit,
        input int lat_fx1,
        input int lat_byte,
        input int lat_fx2,
        input int lat_spfp,
        input int lat_spint,
        input int lat_perm,
        input int lat_ls,
        input int max_lat
    );
        case (unit)
            UNIT_FX1:   return lat_fx1;
            UNIT_BYTE:  return lat_byte;
            UNIT_FX2:   return lat_fx2;
            UNIT_SPFP:  return lat_spfp;
            UNIT_SPINT: return lat_spint;
            UNIT_PERM:  return lat_perm;
            UNIT_LS:    return lat_ls;
            default:    return max_lat;
        endcase
    endfunction

endpackage

// File: rtl/issue_hazard_scoreboard_wb_reservation.sv
// rtl/issue_hazard_scoreboard_wb_reservation.sv - one pipe's writeback-slot reservation shift vector
module wb_reservation #(
    parameter int MAX_LAT = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [$clog2(MAX_LAT+1)-1:0]     lat,
    input  logic                             set,
    output logic                             busy
);

    logic [MAX_LAT:1] resv;
    logic [MAX_LAT:0] full;
    logic [MAX_LAT:0] mask;

    assign full = {resv, 1'b0};
    assign busy = full[lat];
    // Bit lat-1 of the post-shift vector, i.e. the slot the new result will occupy next cycle.
    assign mask = ({{MAX_LAT{1'b0}}, 1'b1} << lat) >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            resv <= '0;
        end else begin
            resv <= {1'b0, resv[MAX_LAT:2]} | (set ? mask[MAX_LAT:1] : '0);
        end
    end

endmodule

// File: rtl/issue_hazard_scoreboard.sv
// rtl/issue_hazard_scoreboard.sv - dual-issue RAW/WAW/writeback-slot hazard scoreboard
// Optional perf counters: ISSUE_HAZARD_PERF_CNT_EN
module issue_hazard_scoreboard
    import issue_hazard_scoreboard_pkg::*;
#(
    parameter int LAT_FX1   = 2,
    parameter int LAT_BYTE  = 3,
    parameter int LAT_FX2   = 3,
    parameter int LAT_SPFP  = 6,
    parameter int LAT_SPINT = 7,
    parameter int LAT_PERM  = 3,
    parameter int LAT_LS    = 6,
    parameter int MAX_LAT   = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      even_valid,
    input  logic [UNIT_ID_SIZE-1:0]   even_unit,
    input  logic                      even_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] even_rd,
    input  logic [REG_ADDR_WIDTH-1:0] even_ra,
    input  logic [REG_ADDR_WIDTH-1:0] even_rb,
    input  logic [REG_ADDR_WIDTH-1:0] even_rc,
    input  logic [2:0]                even_src_use,
    input  logic                      odd_valid,
    input  logic [UNIT_ID_SIZE-1:0]   odd_unit,
    input  logic                      odd_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] odd_rd,
    input  logic [REG_ADDR_WIDTH-1:0] odd_ra,
    input  logic [REG_ADDR_WIDTH-1:0] odd_rb,
    input  logic [REG_ADDR_WIDTH-1:0] odd_rc,
    input  logic [2:0]                odd_src_use,
    input  logic                      odd_older,
    output logic                      even_issue,
    output logic                      odd_issue,
    output logic                      stall
`ifdef ISSUE_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               perf_data_stalls,
    output logic [31:0]               perf_struct_stalls
`endif
);

    localparam int CW   = $clog2(MAX_LAT + 1);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] lat_e, lat_o;
    logic          busy_e, busy_o;
    logic          rdy_e, rdy_o, ok_e, ok_o;
    logic          o_valid, o_ok, o_we, y_ok, y_we, iss_o, iss_y;
    logic [REG_ADDR_WIDTH-1:0] o_rd, y_rd, y_ra, y_rb, y_rc;
    logic [2:0]    y_use;
    logic          raw, waw;
    logic          wr_e, wr_o;

    function automatic logic src_ready(
        input logic [2:0]                use_v,
        input logic [REG_ADDR_WIDTH-1:0] ra,
        input logic [REG_ADDR_WIDTH-1:0] rb,
        input logic [REG_ADDR_WIDTH-1:0] rc
    );
        return (!use_v[0] || cnt[ra] == '0) &&
               (!use_v[1] || cnt[rb] == '0) &&
               (!use_v[2] || cnt[rc] == '0);
    endfunction

    assign lat_e = CW'(unit_lat(even_unit, LAT_FX1, LAT_BYTE, LAT_FX2, LAT_SPFP,
                                LAT_SPINT, LAT_PERM, LAT_LS, MAX_LAT));
    assign lat_o = CW'(unit_lat(odd_unit, LAT_FX1, LAT_BYTE, LAT_FX2, LAT_SPFP,
                                LAT_SPINT, LAT_PERM, LAT_LS, MAX_LAT));

    assign rdy_e = src_ready(even_src_use, even_ra, even_rb, even_rc);
    assign rdy_o = src_ready(odd_src_use, odd_ra, odd_rb, odd_rc);
    assign ok_e  = even_valid && rdy_e && !(even_rd_we && busy_e);
    assign ok_o  = odd_valid && rdy_o && !(odd_rd_we && busy_o);

    // Steer slots into older/younger roles so the pairing rules are written once.
    always_comb begin
        o_valid = even_valid;
        o_ok    = ok_e;
        o_we    = even_rd_we;
        o_rd    = even_rd;
        y_ok    = ok_o;
        y_we    = odd_rd_we;
        y_rd    = odd_rd;
        y_ra    = odd_ra;
        y_rb    = odd_rb;
        y_rc    = odd_rc;
        y_use   = odd_src_use;
        if (odd_older) begin
            o_valid = odd_valid;
            o_ok    = ok_o;
            o_we    = odd_rd_we;
            o_rd    = odd_rd;
            y_ok    = ok_e;
            y_we    = even_rd_we;
            y_rd    = even_rd;
            y_ra    = even_ra;
            y_rb    = even_rb;
            y_rc    = even_rc;
            y_use   = even_src_use;
        end
    end

    assign raw   = o_valid && o_we && ((y_use[0] && y_ra == o_rd) ||
                                       (y_use[1] && y_rb == o_rd) ||
                                       (y_use[2] && y_rc == o_rd));
    assign waw   = o_valid && o_we && y_we && (y_rd == o_rd);
    assign iss_o = o_ok;
    assign iss_y = y_ok && (iss_o || !o_valid) && !raw && !waw;

    assign even_issue = !reset && (odd_older ? iss_y : iss_o);
    assign odd_issue  = !reset && (odd_older ? iss_o : iss_y);
    assign stall      = !reset && ((even_valid && !even_issue) || (odd_valid && !odd_issue));

    assign wr_e = even_issue && even_rd_we;
    assign wr_o = odd_issue && odd_rd_we;

    wb_reservation #(.MAX_LAT(MAX_LAT)) u_resv_e (
        .clk   (clk),
        .reset (reset),
        .lat   (lat_e),
        .set   (wr_e),
        .busy  (busy_e)
    );

    wb_reservation #(.MAX_LAT(MAX_LAT)) u_resv_o (
        .clk   (clk),
        .reset (reset),
        .lat   (lat_o),
        .set   (wr_o),
        .busy  (busy_o)
    );

    // A fresh load beats the decrement: the newest producer defines readiness.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (reset) begin
                cnt[r] <= '0;
            end else if (wr_e && even_rd == REG_ADDR_WIDTH'(r)) begin
                cnt[r] <= lat_e - CW'(1);
            end else if (wr_o && odd_rd == REG_ADDR_WIDTH'(r)) begin
                cnt[r] <= lat_o - CW'(1);
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

`ifdef ISSUE_HAZARD_PERF_CNT_EN
    logic struct_e, struct_o, data_e, data_o, y_is_even;

    assign y_is_even = !odd_older;
    assign struct_e  = even_valid && even_rd_we && busy_e;
    assign struct_o  = odd_valid && odd_rd_we && busy_o;
    assign data_e    = even_valid && !even_issue && !struct_e &&
                       (!rdy_e || (y_is_even && (raw || waw)));
    assign data_o    = odd_valid && !odd_issue && !struct_o &&
                       (!rdy_o || (!y_is_even && (raw || waw)));

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_data_stalls   <= '0;
            perf_struct_stalls <= '0;
        end else begin
            if (data_e || data_o)
                perf_data_stalls <= perf_data_stalls + 32'd1;
            if (struct_e || struct_o)
                perf_struct_stalls <= perf_struct_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_hazard_scoreboard.sv
// tb/tb_issue_hazard_scoreboard.sv - scoreboard-driven self-checking bench for issue_hazard_scoreboard
module tb_issue_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       even_valid, odd_valid, even_rd_we, odd_rd_we, odd_older;
    logic [2:0] even_unit, odd_unit, even_src_use, odd_src_use;
    logic [6:0] even_rd, even_ra, even_rb, even_rc;
    logic [6:0] odd_rd, odd_ra, odd_rb, odd_rc;
    logic       even_issue, odd_issue, stall;
`ifdef ISSUE_HAZARD_PERF_CNT_EN
    logic [31:0] perf_data_stalls, perf_struct_stalls;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  e;
        logic  o;
        logic  s;
        string tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    issue_hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .even_valid   (even_valid),
        .even_unit    (even_unit),
        .even_rd_we   (even_rd_we),
        .even_rd      (even_rd),
        .even_ra      (even_ra),
        .even_rb      (even_rb),
        .even_rc      (even_rc),
        .even_src_use (even_src_use),
        .odd_valid    (odd_valid),
        .odd_unit     (odd_unit),
        .odd_rd_we    (odd_rd_we),
        .odd_rd       (odd_rd),
        .odd_ra       (odd_ra),
        .odd_rb       (odd_rb),
        .odd_rc       (odd_rc),
        .odd_src_use  (odd_src_use),
        .odd_older    (odd_older),
        .even_issue   (even_issue),
        .odd_issue    (odd_issue),
        .stall        (stall)
`ifdef ISSUE_HAZARD_PERF_CNT_EN
        ,
        .perf_data_stalls   (perf_data_stalls),
        .perf_struct_stalls (perf_struct_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic set_even(input logic v, input logic [2:0] unit, input logic we,
                            input logic [6:0] rd, input logic [6:0] ra, input logic [2:0] use_v);
        even_valid = v; even_unit = unit; even_rd_we = we; even_rd = rd;
        even_ra = ra; even_rb = 7'd0; even_rc = 7'd0; even_src_use = use_v;
    endtask

    task automatic set_odd(input logic v, input logic [2:0] unit, input logic we,
                           input logic [6:0] rd, input logic [6:0] ra, input logic [2:0] use_v);
        odd_valid = v; odd_unit = unit; odd_rd_we = we; odd_rd = rd;
        odd_ra = ra; odd_rb = 7'd0; odd_rc = 7'd0; odd_src_use = use_v;
    endtask

    // One cycle: push the expectation, compare at the falling edge, then advance past the rising edge.
    task automatic cyc(input logic e, input logic o, input logic s, input string tag);
        exp_t x;
        x.e = e; x.o = o; x.s = s; x.tag = tag;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        check({x.tag, ".even_issue"}, {31'd0, even_issue}, {31'd0, x.e});
        check({x.tag, ".odd_issue"},  {31'd0, odd_issue},  {31'd0, x.o});
        check({x.tag, ".stall"},      {31'd0, stall},      {31'd0, x.s});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_even(1'b0, 3'd0, 1'b0, 7'd0, 7'd0, 3'd0);
        set_odd(1'b0, 3'd0, 1'b0, 7'd0, 7'd0, 3'd0);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        reset = 1'b1;
        odd_older = 1'b0;
        set_even(1'b1, 3'd0, 1'b1, 7'd1, 7'd2, 3'd1);
        set_odd(1'b1, 3'd5, 1'b1, 7'd3, 7'd4, 3'd1);
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, "reset0");
        cyc(1'b0, 1'b0, 1'b0, "reset1");
        reset = 1'b0;
        idle(1);

        // Independent pair
        set_even(1'b1, 3'd0, 1'b1, 7'd5, 7'd1, 3'b001);
        set_odd(1'b1, 3'd5, 1'b1, 7'd9, 7'd2, 3'b001);
        cyc(1'b1, 1'b1, 1'b0, "indep");
        idle(8);

        // RAW across cycles
        set_even(1'b1, 3'd0, 1'b1, 7'd5, 7'd1, 3'b001);
        cyc(1'b1, 1'b0, 1'b0, "raw_prod");
        set_even(1'b1, 3'd0, 1'b1, 7'd6, 7'd5, 3'b001);
        cyc(1'b0, 1'b0, 1'b1, "raw_t1");
        cyc(1'b1, 1'b0, 1'b0, "raw_t2");
        idle(8);

        // Intra-pair RAW, even older
        set_even(1'b1, 3'd0, 1'b1, 7'd10, 7'd1, 3'b001);
        set_odd(1'b1, 3'd0, 1'b1, 7'd11, 7'd10, 3'b001);
        cyc(1'b1, 1'b0, 1'b1, "pair_t0");
        set_even(1'b0, 3'd0, 1'b0, 7'd0, 7'd0, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, "pair_t1");
        cyc(1'b0, 1'b1, 1'b0, "pair_t2");
        idle(8);

        // Structural writeback collision
        set_even(1'b1, 3'd4, 1'b1, 7'd20, 7'd0, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, "struct_t0");
        set_even(1'b1, 3'd3, 1'b1, 7'd21, 7'd0, 3'b000);
        cyc(1'b0, 1'b0, 1'b1, "struct_t1");
        cyc(1'b1, 1'b0, 1'b0, "struct_t2");
        idle(8);
`ifdef ISSUE_HAZARD_PERF_CNT_EN
        check("perf_struct", perf_struct_stalls, 32'd1);
        check("perf_data", perf_data_stalls, 32'd3);
`endif

        // Intra-pair WAW
        set_even(1'b1, 3'd0, 1'b1, 7'd14, 7'd1, 3'b001);
        set_odd(1'b1, 3'd5, 1'b1, 7'd14, 7'd2, 3'b001);
        cyc(1'b1, 1'b0, 1'b1, "waw_t0");
        set_even(1'b0, 3'd0, 1'b0, 7'd0, 7'd0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, "waw_t1");
        idle(8);

        // Ordering: odd older blocked on ls result holds a ready even
        odd_older = 1'b1;
        set_odd(1'b1, 3'd6, 1'b1, 7'd3, 7'd0, 3'b000);
        cyc(1'b0, 1'b1, 1'b0, "ord_ls");
        set_odd(1'b1, 3'd0, 1'b1, 7'd12, 7'd3, 3'b001);
        set_even(1'b1, 3'd0, 1'b1, 7'd13, 7'd1, 3'b001);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b0, 1'b1, $sformatf("ord_t%0d", i));
        cyc(1'b1, 1'b1, 1'b0, "ord_t6");
        odd_older = 1'b0;
        idle(8);

        // Unknown unit code uses MAX_LAT
        set_even(1'b1, 3'd7, 1'b1, 7'd30, 7'd0, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, "unk_prod");
        set_even(1'b1, 3'd0, 1'b1, 7'd31, 7'd30, 3'b001);
        for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b0, 1'b1, $sformatf("unk_t%0d", i));
        cyc(1'b1, 1'b0, 1'b0, "unk_t7");
        idle(8);

        // Reset mid-stream while cnt[r5] is 4
        set_even(1'b1, 3'd4, 1'b1, 7'd5, 7'd0, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, "rst_prod");
        idle(2);
        set_even(1'b1, 3'd0, 1'b1, 7'd6, 7'd5, 3'b001);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, "rst_hold");
        reset = 1'b0;
`ifdef ISSUE_HAZARD_PERF_CNT_EN
        check("perf_struct_rst", perf_struct_stalls, 32'd0);
        check("perf_data_rst", perf_data_stalls, 32'd0);
`endif
        cyc(1'b1, 1'b0, 1'b0, "rst_reader");
        idle(2);

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_hazard_scoreboard.md
# issue_hazard_scoreboard

Dual-issue hazard scoreboard sitting between the instruction decode/route stage and register fetch. It decides each cycle whether the even-pipe and odd-pipe instructions may enter register fetch. It tracks per-register result readiness (forwarding availability) and per-pipe writeback-slot occupancy. It guarantees that every operand a consumer reads is either in the register file or present in the forwarding stage registers, and that no two results of one pipe collide in the same forwarding stage.

## Interface
Parameters:
- LAT_FX1, 2, fixed-point simple unit result-ready latency (cycles from issue)
- LAT_BYTE, 3, byte unit latency
- LAT_FX2, 3, fixed-point shift/rotate unit latency
- LAT_SPFP, 6, single-precision FP unit latency
- LAT_SPINT, 7, single-precision integer-multiply latency
- LAT_PERM, 3, permute unit latency
- LAT_LS, 6, local-store unit latency
- MAX_LAT, 7, ≥ every LAT_*; sizes the reservation vectors and counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- even_valid / odd_valid  in  1  instruction present in slot
- even_unit / odd_unit  in  UNIT_ID_SIZE  executing-unit code
- even_rd_we / odd_rd_we  in  1  instruction writes rt
- even_rd / odd_rd  in  REG_ADDR_WIDTH  destination register
- even_ra / even_rb / even_rc, odd_ra / odd_rb / odd_rc  in  REG_ADDR_WIDTH  source registers
- even_src_use / odd_src_use  in  3  per-source used flags, bit0=ra, bit1=rb, bit2=rc
- odd_older  in  1  1: odd slot precedes even slot in program order
- even_issue / odd_issue  out  1  combinational grant; instruction consumed when valid & issue
- stall  out  1  some valid instruction not granted this cycle
- perf_data_stalls / perf_struct_stalls  out  32  only with the configuration macro

## Operation
- Readiness counter cnt[r] per register, width clog2(MAX_LAT+1). Source r is ready iff cnt[r]==0.
- Writer issue with latency L: cnt[rd] ← L−1. This overrides any decrement or older value, because the newest producer wins.
- All other nonzero counters decrement by 1 per cycle, saturating at 0.
- Both slots issuing writers: each loads its own rd. Same-rd dual writes are prevented (see WAW below).
- Per-pipe reservation vector resv_e / resv_o, bits 1..MAX_LAT. Bit i set means that pipe writes back i cycles from now.
  - Each cycle the vector shifts toward bit 1.
  - A writer issued with latency L sets bit L−1 of the shifted vector.
  - A slot is structurally blocked if resv[L]==1.
- Slot ok = valid & every used source ready & (!rd_we | resv[L]==0).
- Older slot issues iff ok.
- Younger slot issues iff all of the following hold:
  - ok;
  - older issued or older not valid;
  - no intra-pair RAW: no used source equals older rd while older rd_we;
  - no intra-pair WAW: not both rd_we with equal rd.
- The younger slot never issues ahead of a valid, unissued older slot.
- Unknown unit code: treated as LAT=MAX_LAT.
- Upstream holds slot inputs stable while valid & !issue.
- stall = (even_valid & !even_issue) | (odd_valid & !odd_issue).

## Timing
- Grants are same-cycle combinational from registered state. State updates on the rising edge.
- Producer issued cycle t, latency L: a dependent instruction may issue in cycle t+L at the earliest.
- While reset is high: even_issue=0, odd_issue=0, stall=0, all cnt=0, resv=0, perf counters=0.
- Reset mid-stream drops all tracking; upstream is flushed with it.
- Counter load and decrement on the same register in the same cycle: load wins.

## Configuration
- ISSUE_HAZARD_PERF_CNT_EN defined:
  - perf_data_stalls increments on any cycle where a valid slot is blocked only by source readiness or an intra-pair dependency.
  - perf_struct_stalls increments on any cycle where a valid slot is blocked by a reservation.
  - Both wrap at 2^32 and reset to 0.
- Macro undefined: the ports are absent and no counter logic is built.

## Structure
- Shared package (existing): UNIT_ID_SIZE, REG_ADDR_WIDTH, unit-code enum, and a latency lookup function keyed by unit code.
- Sub-module wb_reservation: one shift/reservation vector with check and set. Instantiated twice, even and odd.

## Test plan
- Independent pair: even fx1 writes r5, odd perm writes r9, no shared sources → both issue cycle 0, stall=0.
- RAW across cycles: even fx1 writes r5 at t=0; next even reads r5 → blocked t=1, issues t=2.
- Intra-pair RAW: even (older) writes r10, odd reads r10 → even issues. Odd waits for LAT_FX1 of r10 (issues t=2), not merely t=1.
- Structural: even sp_int (L=7) at t=0, even sp_fp (L=6) at t=1 targeting the same writeback slot → sp_fp blocked t=1, issues t=2. Struct counter = 1.
- Ordering: odd older and blocked on r3 from ls (L=6) → even is held as well, despite being ready.
- Reset asserted while cnt[r5]=4 → next cycle a reader of r5 issues immediately; outputs are 0 during reset.
